// File: rtl/wb_periph_interconnect.sv
// Wishbone classic single-master to N-peripheral interconnect with decode error.
// Optional hung-slave watchdog enabled by defining PERIPH_TIMEOUT_EN.
module wb_periph_interconnect #(
  parameter int NUM_PERIPH     = 8,
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 32,
  parameter int SEL_LSB        = 28,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cyc_i,
  input  logic                             stb_i,
  input  logic                             we_i,
  input  logic [ADDR_WIDTH-1:0]            addr_i,
  input  logic [DATA_WIDTH-1:0]            data_i,
  output logic [DATA_WIDTH-1:0]            data_o,
  output logic                             ack_o,
  output logic                             err_o,
  output logic [NUM_PERIPH-1:0]            periph_cyc_o,
  output logic [NUM_PERIPH-1:0]            periph_stb_o,
  output logic                             periph_we_o,
  output logic [ADDR_WIDTH-1:0]            periph_addr_o,
  output logic [DATA_WIDTH-1:0]            periph_data_o,
  input  logic [NUM_PERIPH-1:0]            periph_ack_i,
  input  logic [NUM_PERIPH*DATA_WIDTH-1:0] periph_data_i
);

  localparam int SEL_W = $clog2(NUM_PERIPH);
  localparam logic [SEL_W:0] NUM_P = (SEL_W+1)'(NUM_PERIPH);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    RESP
  } state_t;

  state_t                  state_q, state_d;
  logic [SEL_W-1:0]        idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic [NUM_PERIPH-1:0]   cyc_q, cyc_d;
  logic [SEL_W-1:0]        field;
  logic                    sel_ack;
  logic [DATA_WIDTH-1:0]   sel_data;

`ifdef PERIPH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  assign field         = addr_i[SEL_LSB +: SEL_W];
  assign periph_we_o   = we_i;
  assign periph_addr_o = addr_i;
  assign periph_data_o = data_i;
  assign periph_cyc_o  = cyc_q;
  assign periph_stb_o  = cyc_q;
  assign data_o        = data_q;
  assign ack_o         = ack_q;
  assign err_o         = err_q;

  always_comb begin
    sel_ack  = 1'b0;
    sel_data = '0;
    for (int k = 0; k < NUM_PERIPH; k++) begin
      if (idx_q == SEL_W'(k)) begin
        sel_ack  = periph_ack_i[k];
        sel_data = periph_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    cyc_d   = '0;
`ifdef PERIPH_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cyc_i && stb_i) begin
          idx_d = field;
          if ({1'b0, field} < NUM_P) begin
            state_d = ACTIVE;
            cyc_d   = NUM_PERIPH'(1) << field;
`ifdef PERIPH_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            state_d = RESP;
            err_d   = 1'b1;
            data_d  = '0;
          end
        end
      end
      ACTIVE: begin
        // Abort beats a same-cycle ack.
        if (!cyc_i) begin
          state_d = IDLE;
        end else if (sel_ack) begin
          state_d = RESP;
          ack_d   = 1'b1;
          data_d  = sel_data;
`ifdef PERIPH_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = RESP;
          err_d   = 1'b1;
          data_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          cyc_d = NUM_PERIPH'(1) << idx_q;
        end
`else
        end else begin
          cyc_d = NUM_PERIPH'(1) << idx_q;
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      cyc_q   <= '0;
`ifdef PERIPH_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
`ifdef PERIPH_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_wb_periph_interconnect.sv
// Directed self-checking bench for wb_periph_interconnect (NUM_PERIPH = 6).
// Timeout scenarios run when PERIPH_TIMEOUT_EN is defined.
module tb_wb_periph_interconnect;

  localparam int NP = 6;
  localparam int DW = 64;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            cyc_i, stb_i, we_i;
  logic [AW-1:0]   addr_i;
  logic [DW-1:0]   data_i;
  logic [DW-1:0]   data_o;
  logic            ack_o, err_o;
  logic [NP-1:0]   periph_cyc_o, periph_stb_o;
  logic            periph_we_o;
  logic [AW-1:0]   periph_addr_o;
  logic [DW-1:0]   periph_data_o;
  logic [NP-1:0]   periph_ack_i;
  logic [NP*DW-1:0] periph_data_i;

  int checks = 0;
  int errors = 0;

  wb_periph_interconnect #(
    .NUM_PERIPH(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .SEL_LSB(28), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .addr_i(addr_i), .data_i(data_i), .data_o(data_o),
    .ack_o(ack_o), .err_o(err_o),
    .periph_cyc_o(periph_cyc_o), .periph_stb_o(periph_stb_o),
    .periph_we_o(periph_we_o), .periph_addr_o(periph_addr_o),
    .periph_data_o(periph_data_o), .periph_ack_i(periph_ack_i),
    .periph_data_i(periph_data_i)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [AW-1:0] a, input logic w,
                     input logic [DW-1:0] d);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = w; addr_i = a; data_i = d;
  endtask

  task automatic idle_bus();
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_bus();
    addr_i = '0; data_i = '0; periph_ack_i = '0;
    for (int k = 0; k < NP; k++)
      periph_data_i[k*DW +: DW] = {32'hDEAD_BEEF, 32'(k)};
    step(); step();
    checks++;
    if (ack_o !== 1'b0 || err_o !== 1'b0 || data_o !== '0 ||
        periph_cyc_o !== '0 || periph_stb_o !== '0) begin
      errors++;
      $display("FAIL reset: ack=%b err=%b data=%h cyc=%b stb=%b want all 0",
               ack_o, err_o, data_o, periph_cyc_o, periph_stb_o);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_read();
    req(32'h3000_0010, 1'b0, '0);
    step();
    checks++;
    if (periph_stb_o !== 6'b001000 || periph_cyc_o !== 6'b001000) begin
      errors++;
      $display("FAIL read_stb: stb=%b cyc=%b want 001000", periph_stb_o, periph_cyc_o);
    end
    checks++;
    if (periph_addr_o !== 32'h3000_0010) begin
      errors++;
      $display("FAIL read_addr: got %h want 30000010", periph_addr_o);
    end
    step();
    checks++;
    if (ack_o !== 1'b0 || periph_stb_o !== 6'b001000) begin
      errors++;
      $display("FAIL read_wait: ack=%b stb=%b want 0/001000", ack_o, periph_stb_o);
    end
    step();
    periph_ack_i = 6'b001000;
    checks++;
    if (ack_o !== 1'b0) begin
      errors++;
      $display("FAIL read_early_ack: got %b want 0", ack_o);
    end
    step();
    periph_ack_i = '0;
    idle_bus();
    checks++;
    if (ack_o !== 1'b1 || err_o !== 1'b0 || data_o !== 64'hDEAD_BEEF_0000_0003) begin
      errors++;
      $display("FAIL read_ack: ack=%b err=%b data=%h want 1/0/deadbeef00000003",
               ack_o, err_o, data_o);
    end
    checks++;
    if (periph_stb_o !== '0) begin
      errors++;
      $display("FAIL read_resp_stb: got %b want 0", periph_stb_o);
    end
    step();
    checks++;
    if (ack_o !== 1'b0) begin
      errors++;
      $display("FAIL read_ack_pulse: got %b want 0", ack_o);
    end
  endtask

  task automatic test_write();
    req(32'h0000_0008, 1'b1, 64'h1234);
    step();
    checks++;
    if (periph_cyc_o !== 6'h01 || periph_we_o !== 1'b1 ||
        periph_data_o !== 64'h1234) begin
      errors++;
      $display("FAIL write_bus: cyc=%b we=%b data=%h want 000001/1/1234",
               periph_cyc_o, periph_we_o, periph_data_o);
    end
    periph_ack_i = 6'b000001;
    step();
    periph_ack_i = '0;
    idle_bus();
    checks++;
    if (ack_o !== 1'b1 || data_o !== 64'hDEAD_BEEF_0000_0000) begin
      errors++;
      $display("FAIL write_ack: ack=%b data=%h want 1/deadbeef00000000", ack_o, data_o);
    end
    step();
  endtask

  task automatic test_decode_err();
    logic [3:0] fld [2];
    fld[0] = 4'd7;
    fld[1] = 4'd6;
    for (int i = 0; i < 2; i++) begin
      req({fld[i], 28'h000_0040}, 1'b0, '0);
      step();
      idle_bus();
      checks++;
      if (err_o !== 1'b1 || ack_o !== 1'b0 || data_o !== '0 ||
          periph_cyc_o !== '0 || periph_stb_o !== '0) begin
        errors++;
        $display("FAIL decode_err[%0d]: err=%b ack=%b data=%h cyc=%b want 1/0/0/0",
                 fld[i], err_o, ack_o, data_o, periph_cyc_o);
      end
      step();
      checks++;
      if (err_o !== 1'b0) begin
        errors++;
        $display("FAIL decode_err_pulse[%0d]: got %b want 0", fld[i], err_o);
      end
      step();
    end
  endtask

`ifdef PERIPH_TIMEOUT_EN
  task automatic test_timeout();
    for (int pass = 0; pass < 2; pass++) begin
      req(32'h5000_0000, 1'b0, '0);
      step();
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (periph_stb_o !== 6'b100000 || err_o !== 1'b0) begin
          errors++;
          $display("FAIL timeout_stb[%0d,%0d]: stb=%b err=%b want 100000/0",
                   pass, i, periph_stb_o, err_o);
        end
        if (pass == 1 && i == 3) periph_ack_i = 6'b100000;
        step();
      end
      periph_ack_i = '0;
      idle_bus();
      checks++;
      if (pass == 0 && (err_o !== 1'b1 || ack_o !== 1'b0 ||
          data_o !== '0 || periph_stb_o !== '0)) begin
        errors++;
        $display("FAIL timeout_err: err=%b ack=%b data=%h stb=%b want 1/0/0/0",
                 err_o, ack_o, data_o, periph_stb_o);
      end else if (pass == 1 && (err_o !== 1'b0 || ack_o !== 1'b1 ||
          data_o !== 64'hDEAD_BEEF_0000_0005)) begin
        errors++;
        $display("FAIL timeout_ack_wins: err=%b ack=%b data=%h want 0/1/deadbeef00000005",
                 err_o, ack_o, data_o);
      end
      step();
    end
  endtask
`else
  task automatic test_no_timeout();
    req(32'h5000_0000, 1'b0, '0);
    for (int i = 0; i < 12; i++) step();
    checks++;
    if (periph_stb_o !== 6'b100000 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout: stb=%b err=%b want 100000/0", periph_stb_o, err_o);
    end
    idle_bus();
    step();
    checks++;
    if (periph_stb_o !== '0 || err_o !== 1'b0 || ack_o !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout_abort: stb=%b err=%b ack=%b want 0", periph_stb_o, err_o, ack_o);
    end
    step();
  endtask
`endif

  task automatic test_stray_and_abort();
    req(32'h1000_0000, 1'b0, '0);
    step();
    periph_ack_i = 6'b000100;
    step();
    checks++;
    if (ack_o !== 1'b0 || periph_stb_o !== 6'b000010) begin
      errors++;
      $display("FAIL stray_ack: ack=%b stb=%b want 0/000010", ack_o, periph_stb_o);
    end
    periph_ack_i = 6'b000010;
    idle_bus();
    step();
    periph_ack_i = '0;
    checks++;
    if (ack_o !== 1'b0 || err_o !== 1'b0 || periph_stb_o !== '0 || periph_cyc_o !== '0) begin
      errors++;
      $display("FAIL abort: ack=%b err=%b stb=%b cyc=%b want 0", ack_o, err_o,
               periph_stb_o, periph_cyc_o);
    end
    step();
    checks++;
    if (ack_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_late_ack: got %b want 0", ack_o);
    end
  endtask

  task automatic test_reset_mid();
    req(32'h2000_0000, 1'b0, '0);
    step();
    periph_ack_i = 6'b000100;
    rst = 1'b1;
    idle_bus();
    step();
    rst = 1'b0;
    periph_ack_i = '0;
    checks++;
    if (ack_o !== 1'b0 || err_o !== 1'b0 || data_o !== '0 || periph_stb_o !== '0) begin
      errors++;
      $display("FAIL reset_mid: ack=%b err=%b data=%h stb=%b want 0", ack_o, err_o,
               data_o, periph_stb_o);
    end
    req(32'h2000_0000, 1'b0, '0);
    step();
    checks++;
    if (periph_stb_o !== 6'b000100) begin
      errors++;
      $display("FAIL reset_mid_restart: stb=%b want 000100", periph_stb_o);
    end
    periph_ack_i = 6'b000100;
    step();
    periph_ack_i = '0;
    idle_bus();
    checks++;
    if (ack_o !== 1'b1 || data_o !== 64'hDEAD_BEEF_0000_0002) begin
      errors++;
      $display("FAIL reset_mid_ack: ack=%b data=%h want 1/deadbeef00000002", ack_o, data_o);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_decode_err();
`ifdef PERIPH_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_stray_and_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_periph_interconnect.md
Name: wb_periph_interconnect

Overview:
- Parametrised Wishbone classic single-master to N-peripheral interconnect. It sits between the core's data-bus master and the peripheral slaves.
- Decodes a configurable address field and registers the transaction in a small FSM.
- Forwards cyc/stb only to the selected peripheral and returns a registered ack/data.
- Adds a decode-error response for out-of-range indices and an optional watchdog timeout for hung slaves.

Parameters:
- NUM_PERIPH, 8, number of peripheral ports (2..16).
- DATA_WIDTH, 64, data bus width.
- ADDR_WIDTH, 32, address bus width.
- SEL_LSB, 28, lowest address bit of the peripheral-select field; field width SEL_W = $clog2(NUM_PERIPH), field = addr_i[SEL_LSB+SEL_W-1:SEL_LSB]; SEL_LSB+SEL_W <= ADDR_WIDTH.
- TIMEOUT_CYCLES, 255, cycles in ACTIVE without ack before error (used only with PERIPH_TIMEOUT_EN).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- cyc_i  input  1  master bus cycle active
- stb_i  input  1  master strobe
- we_i  input  1  1 = write, 0 = read
- addr_i  input  ADDR_WIDTH  master address
- data_i  input  DATA_WIDTH  master write data
- data_o  output  DATA_WIDTH  registered read data to master
- ack_o  output  1  registered transfer acknowledge, 1-cycle pulse
- err_o  output  1  registered error (decode or timeout), 1-cycle pulse
- periph_cyc_o  output  NUM_PERIPH  per-peripheral cyc, one-hot or zero
- periph_stb_o  output  NUM_PERIPH  per-peripheral stb, one-hot or zero
- periph_we_o  output  1  broadcast of we_i
- periph_addr_o  output  ADDR_WIDTH  broadcast of addr_i
- periph_data_o  output  DATA_WIDTH  broadcast of data_i
- periph_ack_i  input  NUM_PERIPH  per-peripheral ack
- periph_data_i  input  NUM_PERIPH*DATA_WIDTH  flattened read data; peripheral k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Clock and reset: single clock clk. rst is synchronous, active-high, sampled on the rising edge.
- Reset values: FSM = IDLE; data_o = 0, ack_o = 0, err_o = 0; periph_cyc_o/stb_o = 0; latched index = 0; timeout counter = 0.
- Broadcast: periph_we_o, periph_addr_o and periph_data_o are combinational copies of the master inputs. Masters hold them stable until ack/err.
- FSM states: IDLE, ACTIVE, RESP.
- IDLE: on cyc_i & stb_i, latch idx = select field.
  - If idx < NUM_PERIPH: go to ACTIVE and clear the counter.
  - Otherwise: go to RESP with err_o = 1 and data_o = 0 (decode error).
  - No peripheral sees cyc/stb for a decode error.
- ACTIVE: periph_cyc_o[idx] = periph_stb_o[idx] = 1, all other bits 0 (registered outputs).
  - On periph_ack_i[idx]: capture that peripheral's data into data_o, set ack_o, go to RESP.
  - Acks from non-selected peripherals are ignored.
- RESP: ack_o or err_o is high for exactly this cycle; periph_cyc_o/stb_o = 0; next state IDLE.
  - A new request is accepted no earlier than the cycle after RESP, so back-to-back throughput is 1 transfer per 3 + slave-latency cycles.
- Latency, zero-wait slave (acks in the first ACTIVE cycle):
  - Request seen at edge 0; peripheral stb high in cycle 1.
  - Ack sampled at edge 1; ack_o high in cycle 2.
  - A slave that acks L cycles after stb gives ack_o L+1 cycles after stb.
- Abort: if cyc_i = 0 in ACTIVE, return to IDLE next edge with all peripheral strobes 0 and no ack_o/err_o. Abort takes priority over a same-cycle peripheral ack.
- Write data: on a write, data_o is still updated from the peripheral's data bus at ack; masters ignore it.
- Reset mid-transaction: all outputs return to reset values on the next edge; any in-flight ack is discarded.
- ack_o and err_o are never high together.

Optional Feature:
- Macro: PERIPH_TIMEOUT_EN.
- Defined:
  - The counter increments each ACTIVE cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES-1 with no ack, go to RESP with err_o = 1, data_o = 0, and peripheral strobes dropped.
  - An ack arriving on that same cycle wins: normal ack, no error.
- Not defined: no counter logic is synthesised; ACTIVE waits indefinitely; err_o only signals decode errors.

Test Plan:
- Read, NUM_PERIPH = 8, SEL_LSB = 28, addr_i = 0x3000_0010, slave 3 acks 2 cycles after stb with data 0xDEAD_BEEF_0000_0003 -> only periph_stb_o[3] high; ack_o = 1 for one cycle, 3 cycles after stb; data_o = 0xDEAD_BEEF_0000_0003.
- Write to addr 0x0000_0008, data 0x1234, slave 0 zero-wait -> periph_cyc_o = 8'h01, periph_we_o = 1, periph_data_o = 0x1234; ack_o pulses 2 cycles after request.
- NUM_PERIPH = 6, select field = 7 -> no peripheral strobed; err_o = 1 one cycle after request; ack_o = 0; data_o = 0.
- PERIPH_TIMEOUT_EN, TIMEOUT_CYCLES = 4, slave 5 never acks -> stb high exactly 4 cycles, then err_o pulse; FSM back to IDLE. Repeat with ack on the 4th cycle -> ack_o, no err_o.
- Stray periph_ack_i[2] during a transfer to slave 1 -> ignored; cyc_i dropped mid-ACTIVE with a same-cycle slave ack -> no ack_o, all strobes 0 next cycle.
- Assert rst while ACTIVE -> next cycle all outputs 0; a subsequent request completes normally.
